env_vca: RTL and testbench
==========================

# env_vca

Amplitude envelope generator and voltage-controlled amplifier (VCA) placed directly after the sawtooth oscillator. It takes the oscillator's unsigned wave sample and a gate signal. It runs a five-state ADSR envelope at a programmable rate and outputs the sample scaled by the envelope level, ready for the `uo_out` pins or a later DAC stage.

## Interface
Parameters:
- `WAVE_BITS`, 8, width of the input and output wave samples.
- `ENV_BITS`, 8, width of the envelope level. Maximum level is `2^ENV_BITS-1`.
- `RATE_BITS`, 8, width of the attack, decay and release rate fields.

Ports:
- `clk`  in  1  clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  envelope tick, for example an octave-divider enable. Envelope prescaler and level advance only on cycles where it is high.
- `gate`  in  1  note on (1) / note off (0). Level-sensitive; sampled every cycle.
- `wave_in`  in  WAVE_BITS  unsigned oscillator sample.
- `attack_rate`, `decay_rate`, `release_rate`  in  RATE_BITS each  ticks per envelope step, minus 1.
- `sustain_level`  in  ENV_BITS  sustain target level.
- `wave_out`  out  WAVE_BITS  scaled sample, registered.
- `env_out`  out  ENV_BITS  current envelope level, registered.
- `state_out`  out  3  envelope state: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.

## Operation
- Registers:
  - `state`
  - `env` (ENV_BITS)
  - `presc` (RATE_BITS)
  - `wave_out`
- Active rate: ATTACK uses `attack_rate`, DECAY uses `decay_rate`, RELEASE uses `release_rate`. IDLE and SUSTAIN have no rate.
- Prescaler, on `enable`=1 in ATTACK, DECAY or RELEASE:
  - If `presc >= rate`: take one step and set `presc <= 0`.
  - Otherwise: `presc <= presc+1`.
  - The `>=` comparison makes a mid-count rate decrease fire on the next tick.
- A step changes `env` by ±1 only. `env` never wraps.
- Gate transitions are evaluated every clock, independent of `enable`. They take priority over steps in the same cycle. Any state change forces `presc <= 0`.
  - IDLE or RELEASE with `gate`=1 → ATTACK. `env` is kept as is; no restart from 0.
  - ATTACK, DECAY or SUSTAIN with `gate`=0 → RELEASE.
- Level transitions, applied when no gate transition occurs:
  - ATTACK: a step does `env+1`. If the result equals the maximum, go to DECAY on the same edge. If `env` is already at the maximum when entering ATTACK, go to DECAY on the next edge without stepping.
  - DECAY: if `env <= sustain_level`, go to SUSTAIN on this edge with no step. Otherwise a step does `env-1`.
  - SUSTAIN: `env` holds. If `sustain_level < env`, go back to DECAY. A raised `sustain_level` does not raise `env`.
  - RELEASE: a step does `env-1`. If the result is 0, go to IDLE on the same edge. If `env`=0 on entry, go to IDLE on the next edge.
  - IDLE: `env` holds. It is 0 except after an external reset edge case (none exist).
- VCA:
  - Every clock, independent of `enable`: `wave_out <= (wave_in * (env+1)) >> ENV_BITS`.
  - The product is unsigned, WAVE_BITS+ENV_BITS+1 bits wide, and is truncated (no rounding).
  - `env`=max gives `wave_out = wave_in`. `env`=0 gives `wave_out = 0` when WAVE_BITS ≤ ENV_BITS.
- `env_out` = `env`; `state_out` = `state`.

## Timing
- Reset (synchronous, dominant over all other inputs): `state`=IDLE, `env`=0, `presc`=0, `wave_out`=0. Consequently `env_out`=0 and `state_out`=0 on the first edge after `reset` is asserted. A reset in mid-envelope aborts immediately, with no release.
- Gate to state: 1 cycle. A `gate` rise at edge n gives `state_out`=ATTACK after edge n.
- With `enable` held high at rate r, one step occurs every r+1 cycles, starting r+1 cycles after the state is entered.
  - Full attack from 0 takes 255·(r+1) cycles for ENV_BITS=8.
- `wave_in` to `wave_out`: 1 cycle. It uses the `env` value registered before that edge.
- `gate` pulses shorter than one clock are not captured. Pulses that land on non-`enable` cycles are still captured.

## Test plan
- Reset: hold `reset` 2 cycles with `gate`=1 and `wave_in`=200 → `wave_out`=0, `env_out`=0, `state_out`=0. On release of reset, `state_out`=1 one cycle later.
- Attack/decay: `attack_rate`=0, `decay_rate`=1, `sustain_level`=128, `enable`=1, `gate`=1 from IDLE.
  - `env_out` reaches 255 after 255 cycles and `state_out`=2.
  - `env_out` reaches 128 after a further 254 cycles.
  - `state_out`=3 on the next edge.
- VCA: `env` held at 255 with `wave_in`=200 → `wave_out`=200. At `env`=127 → 100. At `env`=0 → 0. Each value appears one cycle after `wave_in` is applied.
- Release/retrigger: from SUSTAIN at 128, drop `gate` with `release_rate`=3 → `env` decrements every 4 cycles.
  - Raise `gate` at `env`=100 → ATTACK resumes from 100, not 0.
  - Drop `gate` fully → IDLE exactly when `env` hits 0.
- Enable gating: `enable` high 1 cycle in 4, `attack_rate`=0 → `env` +1 per 4 clocks. A 1-cycle `gate` drop on a non-enable cycle still enters RELEASE.
- Sustain change: in SUSTAIN at 128, set `sustain_level`=64 → DECAY next edge, then settles at 64. Set it back to 200 → `env` stays 64, `state_out`=3.

Source files
------------

// File: rtl/env_vca.sv
// ADSR amplitude envelope with a one-cycle VCA stage that scales the oscillator
// sample by (env+1) and truncates back to the sample width.
module env_vca #(
    parameter int WAVE_BITS = 8,
    parameter int ENV_BITS  = 8,
    parameter int RATE_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 gate,
    input  logic [WAVE_BITS-1:0] wave_in,
    input  logic [RATE_BITS-1:0] attack_rate,
    input  logic [RATE_BITS-1:0] decay_rate,
    input  logic [RATE_BITS-1:0] release_rate,
    input  logic [ENV_BITS-1:0]  sustain_level,
    output logic [WAVE_BITS-1:0] wave_out,
    output logic [ENV_BITS-1:0]  env_out,
    output logic [2:0]           state_out
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    localparam logic [ENV_BITS-1:0] ENV_MAX = '1;

    state_t               r_state;
    state_t               w_state_n;
    logic [ENV_BITS-1:0]  r_env;
    logic [ENV_BITS-1:0]  w_env_n;
    logic [RATE_BITS-1:0] r_presc;
    logic [RATE_BITS-1:0] w_presc_n;
    logic [RATE_BITS-1:0] w_rate;
    logic                 w_due;
    logic [WAVE_BITS-1:0] r_wave_p1;

    // Unsigned product kept one bit wider than needed, then truncated (no rounding).
    function automatic logic [WAVE_BITS-1:0] vca_scale(
        input logic [WAVE_BITS-1:0] w,
        input logic [ENV_BITS-1:0]  e
    );
        logic [ENV_BITS:0]          e1;
        logic [WAVE_BITS+ENV_BITS:0] prod;
        e1   = {1'b0, e} + (ENV_BITS+1)'(1);
        prod = {{(ENV_BITS+1){1'b0}}, w} * {{WAVE_BITS{1'b0}}, e1};
        return WAVE_BITS'(prod >> ENV_BITS);
    endfunction

    always_comb begin
        w_rate = '0;
        case (r_state)
            S_ATTACK:  w_rate = attack_rate;
            S_DECAY:   w_rate = decay_rate;
            S_RELEASE: w_rate = release_rate;
            default:   w_rate = '0;
        endcase
    end

    assign w_due = (r_presc >= w_rate);

    // Gate transitions first; level transitions and prescaler steps only otherwise.
    always_comb begin
        w_state_n = r_state;
        w_env_n   = r_env;
        w_presc_n = r_presc;
        case (r_state)
            S_IDLE: begin
                if (gate) begin
                    w_state_n = S_ATTACK;
                    w_presc_n = '0;
                end
            end
            S_ATTACK: begin
                if (!gate) begin
                    w_state_n = S_RELEASE;
                    w_presc_n = '0;
                end else if (r_env == ENV_MAX) begin
                    w_state_n = S_DECAY;
                    w_presc_n = '0;
                end else if (enable) begin
                    if (w_due) begin
                        w_env_n   = r_env + ENV_BITS'(1);
                        w_presc_n = '0;
                        if (r_env + ENV_BITS'(1) == ENV_MAX)
                            w_state_n = S_DECAY;
                    end else begin
                        w_presc_n = r_presc + RATE_BITS'(1);
                    end
                end
            end
            S_DECAY: begin
                if (!gate) begin
                    w_state_n = S_RELEASE;
                    w_presc_n = '0;
                end else if (r_env <= sustain_level) begin
                    w_state_n = S_SUSTAIN;
                    w_presc_n = '0;
                end else if (enable) begin
                    if (w_due) begin
                        w_env_n   = r_env - ENV_BITS'(1);
                        w_presc_n = '0;
                    end else begin
                        w_presc_n = r_presc + RATE_BITS'(1);
                    end
                end
            end
            S_SUSTAIN: begin
                if (!gate) begin
                    w_state_n = S_RELEASE;
                    w_presc_n = '0;
                end else if (sustain_level < r_env) begin
                    w_state_n = S_DECAY;
                    w_presc_n = '0;
                end
            end
            S_RELEASE: begin
                if (gate) begin
                    w_state_n = S_ATTACK;
                    w_presc_n = '0;
                end else if (r_env == '0) begin
                    w_state_n = S_IDLE;
                    w_presc_n = '0;
                end else if (enable) begin
                    if (w_due) begin
                        w_env_n   = r_env - ENV_BITS'(1);
                        w_presc_n = '0;
                        if (r_env == ENV_BITS'(1))
                            w_state_n = S_IDLE;
                    end else begin
                        w_presc_n = r_presc + RATE_BITS'(1);
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_env_n   = '0;
                w_presc_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_env   <= '0;
            r_presc <= '0;
        end else begin
            r_state <= w_state_n;
            r_env   <= w_env_n;
            r_presc <= w_presc_n;
        end
    end

    // VCA stage: one register, uses the envelope level from before this edge.
    always_ff @(posedge clk) begin
        if (reset)
            r_wave_p1 <= '0;
        else
            r_wave_p1 <= vca_scale(wave_in, r_env);
    end

    assign wave_out  = r_wave_p1;
    assign env_out   = r_env;
    assign state_out = r_state;

endmodule

// File: tb/tb_env_vca.sv
// Directed bench for env_vca: reset, attack/decay, VCA scaling, release and
// retrigger, enable gating and sustain-level changes.
module tb_env_vca;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       gate;
    logic [7:0] wave_in;
    logic [7:0] attack_rate;
    logic [7:0] decay_rate;
    logic [7:0] release_rate;
    logic [7:0] sustain_level;
    logic [7:0] wave_out;
    logic [7:0] env_out;
    logic [2:0] state_out;

    int checks   = 0;
    int failures = 0;

    env_vca #(.WAVE_BITS(8), .ENV_BITS(8), .RATE_BITS(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .gate          (gate),
        .wave_in       (wave_in),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .release_rate  (release_rate),
        .sustain_level (sustain_level),
        .wave_out      (wave_out),
        .env_out       (env_out),
        .state_out     (state_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset         = 1'b1;
        enable        = 1'b1;
        gate          = 1'b1;
        wave_in       = 8'd200;
        attack_rate   = 8'd0;
        decay_rate    = 8'd1;
        release_rate  = 8'd3;
        sustain_level = 8'd128;

        tick(2);
        check("rst_wave", wave_out, 0);
        check("rst_env", env_out, 0);
        check("rst_state", state_out, 0);

        reset = 1'b0;
        tick(1);
        check("gate_to_attack", state_out, 1);
        check("vca_env0", wave_out, 0);

        tick(254);
        check("attack_254_env", env_out, 254);
        check("attack_254_state", state_out, 1);
        tick(1);
        check("attack_max_env", env_out, 255);
        check("attack_to_decay", state_out, 2);
        check("vca_env254", wave_out, 199);
        tick(1);
        check("vca_env255", wave_out, 200);
        check("decay_first_hold", env_out, 255);
        tick(253);
        check("decay_reach_env", env_out, 128);
        check("decay_reach_state", state_out, 2);
        tick(1);
        check("to_sustain", state_out, 3);
        check("sustain_env", env_out, 128);

        gate = 1'b0;
        tick(1);
        check("to_release", state_out, 4);
        tick(3);
        check("release_hold3", env_out, 128);
        tick(1);
        check("release_step4", env_out, 127);
        tick(1);
        check("vca_env127", wave_out, 100);
        tick(107);
        check("release_env100", env_out, 100);
        check("release_state", state_out, 4);

        gate = 1'b1;
        tick(1);
        check("retrig_state", state_out, 1);
        check("retrig_env_kept", env_out, 100);
        tick(1);
        check("retrig_step", env_out, 101);

        gate = 1'b0;
        tick(1);
        check("rel2_state", state_out, 4);
        tick(403);
        check("rel2_env1", env_out, 1);
        check("rel2_still_rel", state_out, 4);
        tick(1);
        check("rel2_env0", env_out, 0);
        check("rel2_idle", state_out, 0);

        enable = 1'b0;
        gate   = 1'b1;
        tick(1);
        check("gate_no_enable", state_out, 1);
        for (int g = 0; g < 3; g++) begin
            enable = 1'b1;
            tick(1);
            enable = 1'b0;
            tick(3);
            if (g == 0) check("en_gate_env1", env_out, 1);
        end
        check("en_gate_env3", env_out, 3);
        gate = 1'b0;
        tick(1);
        check("short_drop_rel", state_out, 4);
        check("short_drop_env", env_out, 3);
        gate = 1'b1;
        tick(1);
        check("short_drop_back", state_out, 1);

        enable     = 1'b1;
        decay_rate = 8'd0;
        tick(400);
        check("settle_state", state_out, 3);
        check("settle_env", env_out, 128);
        sustain_level = 8'd64;
        tick(1);
        check("sus_lower_decay", state_out, 2);
        tick(64);
        check("sus_lower_env", env_out, 64);
        tick(1);
        check("sus_lower_state", state_out, 3);
        sustain_level = 8'd200;
        tick(1);
        check("sus_raise_env", env_out, 64);
        check("sus_raise_state", state_out, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
